// File: rtl/cache_fill_fsm_pkg.sv
// cache_pkg: shared state type, block geometry and address helper for the cache fill controller
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
    localparam int ARCH_W = 16;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS = 3;
    function automatic logic [ARCH_W-1:0] block_base(input logic [ARCH_W-1:0] addr);
        return {addr[ARCH_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
    endfunction
endpackage

// File: rtl/cache_fill_fsm_counter.sv
// fill_counter: up-counter with enable, synchronous clear and terminal-count flag
module fill_counter #(
    parameter int W = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over enable so a finishing block restarts at zero
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    // count register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign cnt_o  = cnt_q;
    assign term_o = cnt_q == W'(MAX);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: L1 miss handler that stalls, streams one block from memory, writes the tag and
// emits per-access stat pulses. Define FILL_PERF_EN to add miss_cycles (saturating non-IDLE cycle count).
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ARCH_WIDTH = ARCH_W,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    input  logic [ARCH_WIDTH-1:0]              req_addr,
    input  logic                               tag_hit,
    output logic                               stall,
    output logic                               mem_en,
    output logic [ARCH_WIDTH-1:0]              mem_addr,
    input  logic                               mem_data_valid,
    input  logic [ARCH_WIDTH-1:0]              mem_data_out,
    output logic                               fill_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_idx,
    output logic [ARCH_WIDTH-1:0]              fill_data,
    output logic                               tag_we,
`ifdef FILL_PERF_EN
    output logic [15:0]                        miss_cycles,
`endif
    output logic                               stat_req,
    output logic                               stat_hit
);
    localparam int IW = $clog2(WORDS_PER_BLOCK);

    if (ARCH_WIDTH != ARCH_W || WORDS_PER_BLOCK != (1 << WORD_IDX_BITS) || MEM_LATENCY < 1) begin : g_cfg_err
        $error("cache_fill_fsm: unsupported configuration");
    end

    state_e                state_q, state_d;
    logic [ARCH_WIDTH-1:0] base_q, base_d;
    logic                  replay_q, replay_d;
    logic [IW:0]           issue_cnt;
    logic [IW-1:0]         recv_cnt;
    logic                  issue_term, recv_term, miss, clr;

    assign miss = req_valid & ~tag_hit;
    assign clr  = state_q == DONE;

    fill_counter #(.W(IW + 1), .MAX(WORDS_PER_BLOCK)) u_issue (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(mem_en), .cnt_o(issue_cnt), .term_o(issue_term)
    );
    fill_counter #(.W(IW), .MAX(WORDS_PER_BLOCK - 1)) u_recv (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(fill_we), .cnt_o(recv_cnt), .term_o(recv_term)
    );

    // next state and outputs; reset forces every output low in the same cycle
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        replay_d  = replay_q;
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        tag_we    = 1'b0;
        stat_req  = 1'b0;
        stat_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                stall    = miss;
                stat_req = req_valid & ~replay_q;
                stat_hit = req_valid & tag_hit & ~replay_q;
                replay_d = 1'b0;
                state_d  = miss ? FILL : IDLE;
                base_d   = miss ? block_base(req_addr) : base_q;
            end
            FILL: begin
                stall     = 1'b1;
                mem_en    = ~issue_term;
                mem_addr  = mem_en ? base_q + ARCH_WIDTH'({issue_cnt, 1'b0}) : '0;
                fill_we   = mem_data_valid;
                fill_idx  = fill_we ? recv_cnt : '0;
                fill_data = fill_we ? mem_data_out : '0;
                state_d   = (mem_data_valid && recv_term) ? DONE : FILL;
            end
            DONE: begin
                stall    = 1'b1;
                tag_we   = 1'b1;
                replay_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall     = 1'b0;
            mem_en    = 1'b0;
            mem_addr  = '0;
            fill_we   = 1'b0;
            fill_idx  = '0;
            fill_data = '0;
            tag_we    = 1'b0;
            stat_req  = 1'b0;
            stat_hit  = 1'b0;
        end
    end

    // state, latched block base and replay flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            replay_q <= replay_d;
        end
    end

`ifdef FILL_PERF_EN
    logic [15:0] miss_cycles_q, miss_cycles_d;
    assign miss_cycles_d = (state_q != IDLE && miss_cycles_q != 16'hFFFF) ? miss_cycles_q + 16'd1 : miss_cycles_q;
    // saturating count of cycles spent outside IDLE
    always_ff @(posedge clk) miss_cycles_q <= rst ? '0 : miss_cycles_d;
    assign miss_cycles = miss_cycles_q;
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: vector table, directed miss/wrap/reset sequences and random accesses against a block-level model
module tb_cache_fill_fsm;
    localparam int LAT = 4;
    localparam int WPB = 8;
    localparam int MISS_STALL = 1 + LAT + WPB + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1, req_valid = 1'b0, tag_hit = 1'b0, mem_data_valid = 1'b0;
    logic [15:0] req_addr = '0, mem_data_out = '0;
    logic        stall, mem_en, fill_we, tag_we, stat_req, stat_hit;
    logic [15:0] mem_addr, fill_data;
    logic [2:0]  fill_idx;
`ifdef FILL_PERF_EN
    logic [15:0] miss_cycles;
`endif

    cache_fill_fsm dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .tag_hit(tag_hit),
        .stall(stall), .mem_en(mem_en), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
        .mem_data_out(mem_data_out), .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .tag_we(tag_we),
`ifdef FILL_PERF_EN
        .miss_cycles(miss_cycles),
`endif
        .stat_req(stat_req), .stat_hit(stat_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rv;
        logic        th;
        logic [15:0] a;
        logic        st;
        logic        sr;
        logic        sh;
    } vec_t;
    vec_t vecs [6];

    int          tests = 0, fails = 0, cyc = 0;
    bit          model_tag = 1'b0;
    logic [15:0] seed = 16'hA000;
    bit          pv [8];
    logic [15:0] pa [8];
    bit          tags [int];
    logic        s_stall, s_mem_en, s_fill_we, s_tag_we, s_sr, s_sh;
    logic [15:0] s_mem_addr, s_fill_data;
    logic [2:0]  s_fill_idx;

    function automatic int base_of(input logic [15:0] a);
        return int'(a) - int'(a) % 16;
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // one clock: tag array lookup, sample outputs, memory pipe bookkeeping, then advance
    task automatic tick();
        if (model_tag) tag_hit = tags.exists(base_of(req_addr));
        #2;
        s_stall = stall; s_mem_en = mem_en; s_mem_addr = mem_addr; s_fill_we = fill_we;
        s_fill_idx = fill_idx; s_fill_data = fill_data; s_tag_we = tag_we; s_sr = stat_req; s_sh = stat_hit;
        if (s_mem_en) begin
            pv[(cyc + LAT) % 8] = 1'b1;
            pa[(cyc + LAT) % 8] = s_mem_addr;
        end
        if (s_tag_we) tags[base_of(req_addr)] = 1'b1;
        if (rst) for (int i = 0; i < 8; i++) pv[i] = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        mem_data_valid = pv[cyc % 8];
        mem_data_out = pv[cyc % 8] ? seed + 16'((pa[cyc % 8] >> 1) % 8) : 16'($urandom);
        pv[cyc % 8] = 1'b0;
    endtask

    // present one access until the pipeline is released and compare with the block-level expectation
    task automatic run_access(input logic [15:0] a);
        int base, st, sr, sh, tw, ni, nf, bi, bf, fi, li;
        bit hit, done;
        base = base_of(a);
        hit = tags.exists(base);
        st = 0; sr = 0; sh = 0; tw = 0; ni = 0; nf = 0; bi = 0; bf = 0; fi = -1; li = -1; done = 1'b0;
        req_valid = 1'b1;
        req_addr = a;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            st += int'(s_stall); sr += int'(s_sr); sh += int'(s_sh); tw += int'(s_tag_we);
            if (s_mem_en) begin
                if (int'(s_mem_addr) != base + 2 * ni) bi++;
                if (fi < 0) fi = k;
                li = k;
                ni++;
            end
            if (s_fill_we) begin
                if (int'(s_fill_idx) != nf || s_fill_data !== seed + 16'(nf)) bf++;
                nf++;
            end
            done = !s_stall;
        end
        req_valid = 1'b0;
        check($sformatf("released_%h", a), done, 1);
        check($sformatf("stall_cycles_%h", a), st, hit ? 0 : MISS_STALL);
        check($sformatf("stat_req_%h", a), sr, 1);
        check($sformatf("stat_hit_%h", a), sh, hit ? 1 : 0);
        check($sformatf("tag_we_%h", a), tw, hit ? 0 : 1);
        check($sformatf("issues_%h", a), ni, hit ? 0 : WPB);
        check($sformatf("issue_span_%h", a), li - fi, hit ? 0 : WPB - 1);
        check($sformatf("issue_addr_errs_%h", a), bi, 0);
        check($sformatf("fills_%h", a), nf, hit ? 0 : WPB);
        check($sformatf("fill_errs_%h", a), bf, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b1, 16'h0042, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h0042, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'hFFF8, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; req_valid = 1'b1; tag_hit = 1'b0; req_addr = 16'h1236;
        repeat (2) begin
            tick();
            check("reset_outputs", {s_stall, s_mem_en, s_fill_we, s_tag_we, s_sr, s_sh}, 0);
            check("reset_mem_addr", s_mem_addr, 0);
        end
        rst = 1'b0; req_valid = 1'b0;
        tick();
        check("idle_after_reset", {s_stall, s_mem_en, s_sr}, 0);

        for (int i = 0; i < 6; i++) begin
            rst = 1'b1; req_valid = 1'b0;
            tick();
            rst = 1'b0;
            req_valid = vecs[i].rv; tag_hit = vecs[i].th; req_addr = vecs[i].a;
            tick();
            check($sformatf("vec%0d_stall", i), s_stall, vecs[i].st);
            check($sformatf("vec%0d_stat_req", i), s_sr, vecs[i].sr);
            check($sformatf("vec%0d_stat_hit", i), s_sh, vecs[i].sh);
            check($sformatf("vec%0d_mem_en", i), s_mem_en, 0);
        end
        rst = 1'b1; req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        model_tag = 1'b1;
        seed = 16'hA000;
        run_access(16'h1236);
        run_access(16'h1236);
        seed = 16'($urandom);
        run_access(16'hFFF8);

        req_valid = 1'b1; req_addr = 16'h3004; n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            tick();
            n += int'(s_fill_we);
        end
        check("midfill_responses", n, 3);
        rst = 1'b1;
        tick();
        check("midfill_rst_tag_we", s_tag_we, 0);
        rst = 1'b0; req_valid = 1'b0;
        tick();
        check("midfill_idle_stall", s_stall, 0);
        check("midfill_idle_mem_en", s_mem_en, 0);
        mem_data_valid = 1'b1;
        tick();
        check("stray_fill_we", s_fill_we, 0);
        check("stray_tag_we", s_tag_we, 0);
        run_access(16'h3004);

        for (int t = 0; t < 25; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_quiet", {s_stall, s_sr, s_mem_en, s_fill_we, s_tag_we}, 0);
            end
            seed = 16'($urandom);
            run_access(16'(16'h0400 * $urandom_range(0, 5) + $urandom_range(0, 15)));
        end

`ifdef FILL_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tags.delete();
        run_access(16'h5000);
        run_access(16'h6002);
        check("miss_cycles", miss_cycles, 2 * (MISS_STALL - 1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
